// File: rtl/irrigation_pkg.sv
// Shared types and defaults for the irrigation valve scheduler.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRIP     = 3'd1,
    SPRINKLE = 3'd2,
    DEAD     = 3'd3,
    LOCKOUT  = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_DRIP     = 1'b0,
    GRANT_SPRINKLE = 1'b1
  } grant_e;

  localparam int DEF_MIN_ON_CYCLES = 16;
  localparam int DEF_MAX_ON_CYCLES = 1024;
  localparam int DEF_DEAD_CYCLES   = 4;

  // Pick the next grant from the two requests; a tie goes to the valve not served last.
  function automatic state_e arbitrate(input logic drip_req, input logic spr_req,
                                       input grant_e last);
    if (drip_req && spr_req) return (last == GRANT_DRIP) ? SPRINKLE : DRIP;
    if (drip_req)            return DRIP;
    if (spr_req)             return SPRINKLE;
    return IDLE;
  endfunction

endpackage

// File: rtl/irrigation_scheduler_level_monitor.sv
// Supply level sensor checks: inconsistent-sensor fault, critical low level,
// and (with IRRIGATION_FILL_EN defined) the refill hysteresis flop.
module level_monitor (
  input  logic clk,
  input  logic rst_n,
  input  logic level_low,
  input  logic level_mid,
  input  logic level_high,
  output logic fault,
  output logic critical,
  output logic fill_valvule
);

  assign fault    = (level_high & ~level_mid) | (level_mid & ~level_low);
  assign critical = ~level_low;

`ifdef IRRIGATION_FILL_EN
  // Refill opens below mid and stays open until the high mark; a fault always shuts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   fill_valvule <= 1'b0;
    else if (~level_mid & ~fault) fill_valvule <= 1'b1;
    else if (level_high | fault)  fill_valvule <= 1'b0;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign fill_valvule   = 1'b0;
`endif

endmodule

// File: rtl/irrigation_scheduler.sv
// Shared-supply valve scheduler: one valve at a time, min/max on-time, dead
// gap between grants, lockout on critical level or sensor fault.
// Optional refill control is enabled by defining IRRIGATION_FILL_EN.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int MIN_ON_CYCLES = DEF_MIN_ON_CYCLES,
  parameter int MAX_ON_CYCLES = DEF_MAX_ON_CYCLES,
  parameter int DEAD_CYCLES   = DEF_DEAD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dripper_request,
  input  logic sprinkler_request,
  input  logic level_low,
  input  logic level_mid,
  input  logic level_high,
  output logic dripper_valvule,
  output logic sprinkler_valvule,
  output logic fill_valvule,
  output logic alarm
);

  localparam int CW = $clog2(MAX_ON_CYCLES + 1);
  localparam logic [CW-1:0] MIN_LAST  = CW'(MIN_ON_CYCLES - 1);
  localparam logic [CW-1:0] MAX_LAST  = CW'(MAX_ON_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  state_e        state_q, state_d;
  grant_e        last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault, critical, lock;

  level_monitor u_level (
    .clk          (clk),
    .rst_n        (rst_n),
    .level_low    (level_low),
    .level_mid    (level_mid),
    .level_high   (level_high),
    .fault        (fault),
    .critical     (critical),
    .fill_valvule (fill_valvule)
  );

  assign lock = fault | critical;

  // Next state, dwell counter and last-grant tracking.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE:     state_d = lock ? LOCKOUT
                               : arbitrate(dripper_request, sprinkler_request, last_q);
      DRIP:     if (lock) state_d = LOCKOUT;
                else if ((!dripper_request && cnt_q >= MIN_LAST) || cnt_q == MAX_LAST)
                  state_d = DEAD;
      SPRINKLE: if (lock) state_d = LOCKOUT;
                else if ((!sprinkler_request && cnt_q >= MIN_LAST) || cnt_q == MAX_LAST)
                  state_d = DEAD;
      // The last dead cycle hands straight over through the idle arbitration so the
      // closed gap between two grants is exactly DEAD_CYCLES long.
      DEAD:     if (lock) state_d = LOCKOUT;
                else if (cnt_q == DEAD_LAST)
                  state_d = arbitrate(dripper_request, sprinkler_request, last_q);
      LOCKOUT:  if (!lock) state_d = DEAD;
      default:  state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (state_d == DRIP && state_q != DRIP)         last_d = GRANT_DRIP;
    if (state_d == SPRINKLE && state_q != SPRINKLE) last_d = GRANT_SPRINKLE;
  end

  // State registers with Moore outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      last_q            <= GRANT_SPRINKLE;
      dripper_valvule   <= 1'b0;
      sprinkler_valvule <= 1'b0;
      alarm             <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      last_q            <= last_d;
      dripper_valvule   <= (state_d == DRIP);
      sprinkler_valvule <= (state_d == SPRINKLE);
      alarm             <= (state_d == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler with a cycle-level reference model.
module tb_irrigation_scheduler;

  localparam int MIN_ON = 16;
  localparam int MAX_ON = 32;
  localparam int DEAD_N = 4;
`ifdef IRRIGATION_FILL_EN
  localparam logic FILL_ON = 1'b1;
`else
  localparam logic FILL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dreq = 1'b0, sreq = 1'b0;
  logic lvl_low = 1'b1, lvl_mid = 1'b1, lvl_high = 1'b1;
  logic drip_v, spr_v, fill_v, alarm_v;

  int tests_run = 0;
  int tests_failed = 0;

  irrigation_scheduler #(
    .MIN_ON_CYCLES (MIN_ON),
    .MAX_ON_CYCLES (MAX_ON),
    .DEAD_CYCLES   (DEAD_N)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dripper_request   (dreq),
    .sprinkler_request (sreq),
    .level_low         (lvl_low),
    .level_mid         (lvl_mid),
    .level_high        (lvl_high),
    .dripper_valvule   (drip_v),
    .sprinkler_valvule (spr_v),
    .fill_valvule      (fill_v),
    .alarm             (alarm_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which valve is open and for how long, how many closed
  // cycles are still owed before a new grant, and whether the alarm is up.
  int   m_valve;     // 0 none, 1 dripper, 2 sprinkler
  int   m_open;      // cycles the current valve has been open
  int   m_gap;       // closed cycles still owed, including the current one
  int   m_last;      // valve granted most recently
  logic m_alarm, m_fill;

  always @(posedge clk) begin
    logic flt, lk, req;
    flt = (lvl_high & ~lvl_mid) | (lvl_mid & ~lvl_low);
    lk  = flt | ~lvl_low;
    if (!rst_n) begin
      m_valve = 0; m_open = 0; m_gap = 0; m_last = 2; m_alarm = 1'b0; m_fill = 1'b0;
    end else begin
`ifdef IRRIGATION_FILL_EN
      if (!lvl_mid && !flt) m_fill = 1'b1;
      else if (lvl_high || flt) m_fill = 1'b0;
`endif
      if (lk) begin
        m_valve = 0; m_alarm = 1'b1;
      end else if (m_alarm) begin
        m_alarm = 1'b0; m_gap = DEAD_N;
      end else if (m_valve != 0) begin
        req = (m_valve == 1) ? dreq : sreq;
        if ((!req && m_open >= MIN_ON) || m_open == MAX_ON) begin
          m_valve = 0; m_gap = DEAD_N;
        end else m_open++;
      end else if (m_gap > 1) begin
        m_gap--;
      end else begin
        m_gap = 0;
        if (dreq && (!sreq || m_last == 2)) m_valve = 1;
        else if (sreq) m_valve = 2;
        if (m_valve != 0) begin m_open = 1; m_last = m_valve; end
      end
    end
    #1;
    check("model_drip",  drip_v,  m_valve == 1);
    check("model_spr",   spr_v,   m_valve == 2);
    check("model_alarm", alarm_v, m_alarm);
    check("model_fill",  fill_v,  m_fill);
  end

  task automatic sample();
    @(posedge clk); #1;
  endtask

  function automatic logic pick(input int w);
    case (w)
      0:       return drip_v;
      1:       return spr_v;
      2:       return alarm_v;
      3:       return ~(drip_v | spr_v);
      default: return drip_v | spr_v;
    endcase
  endfunction

  task automatic wait_for(input int w, input logic v, input int budget, input string name);
    int i = 0;
    while (pick(w) != v && i < budget) begin sample(); i++; end
    check(name, pick(w), v);
  endtask

  // Length of the run of value v starting at the current sample.
  task automatic expect_run(input int w, input logic v, input int exp, input string name);
    int n = 0;
    while (pick(w) == v && n <= exp + 4) begin n++; sample(); end
    check(name, n, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    check("reset_drip", drip_v, 1'b0);
    check("reset_spr", spr_v, 1'b0);
    check("reset_alarm", alarm_v, 1'b0);
    check("reset_fill", fill_v, 1'b0);
    do_reset();

    // Both requests held from reset: dripper first, alternating max-length grants.
    dreq = 1'b1; sreq = 1'b1;
    wait_for(0, 1'b1, 8, "both_first_drip");
    expect_run(0, 1'b1, MAX_ON, "both_drip_len");
    expect_run(3, 1'b1, DEAD_N, "both_gap1");
    check("both_alt_spr", spr_v, 1'b1);
    expect_run(1, 1'b1, MAX_ON, "both_spr_len");
    expect_run(3, 1'b1, DEAD_N, "both_gap2");
    check("both_alt_drip", drip_v, 1'b1);
    @(negedge clk); dreq = 1'b0; sreq = 1'b0;
    repeat (30) sample();

    // One-cycle dripper pulse is stretched to the minimum on-time.
    @(negedge clk); dreq = 1'b1;
    @(negedge clk); dreq = 1'b0;
    wait_for(0, 1'b1, 4, "pulse_open");
    expect_run(0, 1'b1, MIN_ON, "pulse_len");
    repeat (10) sample();

    // Critical level mid-grant, then recovery through the dead gap.
    @(negedge clk); dreq = 1'b1;
    wait_for(0, 1'b1, 8, "lock_grant");
    repeat (4) sample();
    @(negedge clk); lvl_low = 1'b0;
    sample();
    check("lock_valve_off", drip_v, 1'b0);
    check("lock_alarm_on", alarm_v, 1'b1);
    repeat (3) sample();
    check("lock_alarm_hold", alarm_v, 1'b1);
    @(negedge clk); lvl_low = 1'b1;
    sample();
    check("lock_alarm_off", alarm_v, 1'b0);
    expect_run(3, 1'b1, DEAD_N, "lock_dead_gap");
    check("lock_regrant", drip_v, 1'b1);
    @(negedge clk); dreq = 1'b0;
    repeat (30) sample();

    // Inconsistent sensors: sprinkler request is refused.
    @(negedge clk); lvl_mid = 1'b0; sreq = 1'b1;
    repeat (6) begin
      sample();
      check("fault_spr_closed", spr_v, 1'b0);
      check("fault_alarm", alarm_v, 1'b1);
    end
    @(negedge clk); lvl_mid = 1'b1; sreq = 1'b0;
    repeat (10) sample();

    // Refill hysteresis.
    @(negedge clk); lvl_high = 1'b0;
    sample(); check("fill_idle", fill_v, 1'b0);
    @(negedge clk); lvl_mid = 1'b0;
    sample(); check("fill_set", fill_v, FILL_ON);
    @(negedge clk); lvl_mid = 1'b1;
    sample(); check("fill_hold", fill_v, FILL_ON);
    @(negedge clk); lvl_high = 1'b1;
    sample(); check("fill_clear", fill_v, 1'b0);

    // Asynchronous reset in the middle of a sprinkler grant.
    @(negedge clk); sreq = 1'b1;
    wait_for(1, 1'b1, 8, "rst_spr_open");
    repeat (3) sample();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_spr", spr_v, 1'b0);
    check("rst_async_drip", drip_v, 1'b0);
    dreq = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_for(4, 1'b1, 8, "rst_regrant");
    check("rst_tie_drip", drip_v, 1'b1);
    check("rst_tie_spr", spr_v, 1'b0);
    @(negedge clk); dreq = 1'b0; sreq = 1'b0;
    repeat (5) sample();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
